// File: rtl/dma_reader_pkg.sv
// Shared constants, FSM encoding and helpers for the DMA read path.
// Bus widths and the default burst size are shared with the writer side.
package dma_reader_pkg;

    localparam int unsigned TXS_ADDR_W        = 23;
    localparam int unsigned TXS_DATA_W        = 128;
    localparam int unsigned TXS_BURST_W       = 6;
    localparam int unsigned WORD_BYTES        = 16;
    localparam int unsigned DEFAULT_MAX_BURST = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCredit = 2'd1,
        StIssue  = 2'd2,
        StDrain  = 2'd3
    } rd_state_e;

    function automatic logic [TXS_ADDR_W-1:0] word_align(input logic [TXS_ADDR_W-1:0] a);
        return {a[TXS_ADDR_W-1:4], 4'h0};
    endfunction

endpackage

// File: rtl/dma_reader_if.sv
// Command, TXS Avalon-MM read and output stream signals of the DMA reader.
// The master modport is the reader's view; slave is the surrounding system's view.
interface dma_reader_if
    import dma_reader_pkg::*;
#(
    parameter int unsigned LEN_W = 12
);
    logic [TXS_ADDR_W-1:0]  cmd_addr;
    logic [LEN_W-1:0]       cmd_len;
    logic                   cmd_valid;
    logic                   cmd_ready;

    logic                   txs_read;
    logic [TXS_ADDR_W-1:0]  txs_address;
    logic [TXS_BURST_W-1:0] txs_burstcount;
    logic                   txs_waitrequest;
    logic [TXS_DATA_W-1:0]  txs_readdata;
    logic                   txs_readdatavalid;

    logic [TXS_DATA_W-1:0]  q;
    logic                   qv;
    logic                   qe;
    logic                   q_ready;
    logic                   busy;

    modport master (
        input  cmd_addr, cmd_len, cmd_valid,
        output cmd_ready,
        output txs_read, txs_address, txs_burstcount,
        input  txs_waitrequest, txs_readdata, txs_readdatavalid,
        output q, qv, qe,
        input  q_ready,
        output busy
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_valid,
        input  cmd_ready,
        input  txs_read, txs_address, txs_burstcount,
        output txs_waitrequest, txs_readdata, txs_readdatavalid,
        input  q, qv, qe,
        output q_ready,
        input  busy
    );

endinterface

// File: rtl/dma_reader_burst_calc.sv
// Combinational burst sizing: largest burst that fits the remaining length without crossing
// a MAX_BURST-word block, plus the FIFO credit check for that burst.
module dma_reader_burst_calc
    import dma_reader_pkg::*;
#(
    parameter int unsigned MAX_BURST  = DEFAULT_MAX_BURST,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic [TXS_ADDR_W-1:0]  cur_addr,
    input  logic [LEN_W-1:0]       rem,
    input  logic [CNT_W-1:0]       fifo_usedw,
    input  logic [CNT_W-1:0]       outstanding,
    output logic [TXS_BURST_W-1:0] blen,
    output logic                   credit_ok
);
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [TXS_BURST_W-1:0] word_idx;
    logic [TXS_BURST_W-1:0] room;
    logic [SUM_W-1:0]       need;

    always_comb begin
        word_idx  = TXS_BURST_W'((cur_addr >> 4) & TXS_ADDR_W'(MAX_BURST - 1));
        room      = TXS_BURST_W'(MAX_BURST) - word_idx;
        blen      = (rem < LEN_W'(room)) ? TXS_BURST_W'(rem) : room;
        // Sum of everything already committed to the FIFO plus this burst.
        need      = SUM_W'(fifo_usedw) + SUM_W'(outstanding) + SUM_W'(blen);
        credit_ok = (need <= SUM_W'(FIFO_DEPTH));
    end

endmodule

// File: rtl/dma_reader.sv
// DMA reader: splits a read command into TXS bursts and streams returned words out of a
// show-ahead FIFO, tagging the final word of each command.
module dma_reader
    import dma_reader_pkg::*;
#(
    parameter int unsigned MAX_BURST  = DEFAULT_MAX_BURST,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned LEN_W      = 12
) (
    input  logic         c,
    input  logic         rst,
    dma_reader_if.master bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    rd_state_e              state_q, state_d;
    logic [TXS_ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       rcv_q, rcv_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic [TXS_ADDR_W-1:0]  txs_address_q, txs_address_d;
    logic [TXS_BURST_W-1:0] txs_burstcount_q, txs_burstcount_d;

    logic [TXS_DATA_W:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       usedw_q, usedw_d;

    logic [TXS_BURST_W-1:0] blen;
    logic                   credit_ok;
    logic                   accept, issue_ok, fifo_wr, pop, qv, last;
    logic [LEN_W-1:0]       rem_after;
    logic [TXS_DATA_W:0]    head;

    dma_reader_burst_calc #(
        .MAX_BURST  (MAX_BURST),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W),
        .CNT_W      (CNT_W)
    ) u_burst_calc (
        .cur_addr    (cur_addr_q),
        .rem         (rem_q),
        .fifo_usedw  (usedw_q),
        .outstanding (outstanding_q),
        .blen        (blen),
        .credit_ok   (credit_ok)
    );

    assign accept    = bus.cmd_valid & (state_q == StIdle);
    assign issue_ok  = (state_q == StIssue) & ~bus.txs_waitrequest;
    // Returns with nothing outstanding are leftovers from before a reset.
    assign fifo_wr   = bus.txs_readdatavalid & (outstanding_q != '0);
    assign qv        = (usedw_q != '0);
    assign pop       = qv & bus.q_ready;
    assign last      = (rcv_q == len_q - LEN_W'(1));
    assign rem_after = rem_q - LEN_W'(txs_burstcount_q);
    assign head      = mem[rd_ptr_q];

    always_comb begin
        state_d          = state_q;
        cur_addr_d       = cur_addr_q;
        rem_d            = rem_q;
        len_d            = len_q;
        txs_address_d    = txs_address_q;
        txs_burstcount_d = txs_burstcount_q;
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    cur_addr_d = word_align(bus.cmd_addr);
                    rem_d      = bus.cmd_len;
                    len_d      = bus.cmd_len;
                    if (bus.cmd_len != '0) state_d = StCredit;
                end
            end
            StCredit: begin
                if (credit_ok) begin
                    txs_address_d    = cur_addr_q;
                    txs_burstcount_d = blen;
                    state_d          = StIssue;
                end
            end
            StIssue: begin
                if (!bus.txs_waitrequest) begin
                    cur_addr_d = cur_addr_q + TXS_ADDR_W'({txs_burstcount_q, 4'h0});
                    rem_d      = rem_after;
                    state_d    = (rem_after == '0) ? StDrain : StCredit;
                end
            end
            StDrain: begin
                if (outstanding_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q
                      + (issue_ok ? CNT_W'(txs_burstcount_q) : '0)
                      - CNT_W'(fifo_wr);
        rcv_d         = accept ? '0 : (fifo_wr ? rcv_q + LEN_W'(1) : rcv_q);
        usedw_d       = usedw_q + CNT_W'(fifo_wr) - CNT_W'(pop);
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            cur_addr_q       <= '0;
            rem_q            <= '0;
            len_q            <= '0;
            rcv_q            <= '0;
            outstanding_q    <= '0;
            txs_address_q    <= '0;
            txs_burstcount_q <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            usedw_q          <= '0;
        end else begin
            state_q          <= state_d;
            cur_addr_q       <= cur_addr_d;
            rem_q            <= rem_d;
            len_q            <= len_d;
            rcv_q            <= rcv_d;
            outstanding_q    <= outstanding_d;
            txs_address_q    <= txs_address_d;
            txs_burstcount_q <= txs_burstcount_d;
            usedw_q          <= usedw_d;
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge c) begin
        if (fifo_wr) mem[wr_ptr_q] <= {last, bus.txs_readdata};
    end

    assign bus.cmd_ready      = (state_q == StIdle);
    assign bus.txs_read       = (state_q == StIssue);
    assign bus.txs_address    = txs_address_q;
    assign bus.txs_burstcount = txs_burstcount_q;
    assign bus.q              = head[TXS_DATA_W-1:0];
    assign bus.qv             = qv;
    assign bus.qe             = qv & head[TXS_DATA_W];
    assign bus.busy           = (state_q != StIdle) | qv;

endmodule

// File: tb/tb_dma_reader.sv
// Directed and randomized bench for dma_reader against an Avalon slave model and a
// reference model of the expected burst list and output word stream.
module tb_dma_reader;
    import dma_reader_pkg::*;

    localparam int unsigned MAXB  = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 12;

    logic c   = 1'b0;
    logic rst = 1'b1;

    dma_reader_if #(.LEN_W(LW)) bus ();

    dma_reader #(
        .MAX_BURST  (MAXB),
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LW)
    ) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    always #5 c = ~c;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_word(input logic [22:0] a);
        logic [31:0] x = {9'd0, a};
        return {x * 32'h9E3779B1, x, ~x, x ^ 32'hC0DE_0000};
    endfunction

    // Avalon slave model and observation state
    logic [22:0]  rsp_q[$];
    logic [28:0]  obs_bursts[$];
    logic [128:0] obs_words[$];
    logic [28:0]  exp_bursts[$];
    logic [128:0] exp_words[$];
    int           stall_left   = 0;
    int           stall_cycles = 0;
    int           hold_viol    = 0;
    int           occ          = 0;
    int           max_occ      = 0;
    int           ready_mode   = 0;
    bit           force_wait   = 0;
    bit           rand_wait    = 0;
    bit           hold_rsp     = 0;
    bit           prev_req_stall = 0;
    bit           prev_hold    = 0;
    logic [28:0]  prev_req;
    logic [129:0] prev_out;

    always @(negedge c) begin
        bus.txs_waitrequest = force_wait || (stall_left > 0 && bus.txs_read) ||
                              (rand_wait && $urandom_range(0, 2) == 0);
        if (stall_left > 0 && bus.txs_read) stall_left--;
        if (!hold_rsp && rsp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            bus.txs_readdatavalid = 1'b1;
            bus.txs_readdata      = mem_word(rsp_q[0]);
        end else begin
            bus.txs_readdatavalid = 1'b0;
            bus.txs_readdata      = '0;
        end
        case (ready_mode)
            0:       bus.q_ready = 1'b1;
            1:       bus.q_ready = ($urandom_range(0, 1) == 1);
            default: bus.q_ready = 1'b0;
        endcase
    end

    always @(posedge c) begin
        if (rst) begin
            occ            = 0;
            prev_req_stall = 0;
            prev_hold      = 0;
        end else begin
            if (prev_req_stall && (!bus.txs_read ||
                {bus.txs_address, bus.txs_burstcount} !== prev_req)) hold_viol++;
            prev_req_stall = 0;
            if (bus.txs_read && bus.txs_waitrequest) begin
                stall_cycles++;
                prev_req_stall = 1;
                prev_req       = {bus.txs_address, bus.txs_burstcount};
            end else if (bus.txs_read) begin
                obs_bursts.push_back({bus.txs_address, bus.txs_burstcount});
                for (int k = 0; k < int'(bus.txs_burstcount); k++)
                    rsp_q.push_back(bus.txs_address + 23'(16 * k));
                occ += int'(bus.txs_burstcount);
            end
            if (prev_hold && {bus.qv, bus.qe, bus.q} !== prev_out) hold_viol++;
            prev_hold = bus.qv && !bus.q_ready;
            prev_out  = {bus.qv, bus.qe, bus.q};
            if (bus.qv && bus.q_ready) begin
                obs_words.push_back({bus.qe, bus.q});
                occ--;
            end
            if (occ > max_occ) max_occ = occ;
        end
        if (bus.txs_readdatavalid) void'(rsp_q.pop_front());
    end

    // Reference: bursts never cross an 8-word block; words follow address order.
    function automatic void build_model(input logic [22:0] addr, input int len);
        logic [22:0] a = {addr[22:4], 4'h0};
        int r = len;
        int b;
        exp_bursts.delete();
        exp_words.delete();
        for (int i = 0; i < len; i++)
            exp_words.push_back({i == len - 1, mem_word(a + 23'(16 * i))});
        while (r > 0) begin
            b = int'(MAXB) - (int'(a / 16) % int'(MAXB));
            if (r < b) b = r;
            exp_bursts.push_back({a, 6'(b)});
            a = a + 23'(16 * b);
            r -= b;
        end
    endfunction

    task automatic compare(input string tag);
        int nb = obs_bursts.size();
        int ne = exp_bursts.size();
        int wb = obs_words.size();
        int we = exp_words.size();
        check({tag, " burst_count"}, 160'(nb), 160'(ne));
        for (int i = 0; i < nb && i < ne; i++)
            check({tag, " burst"}, 160'(obs_bursts[i]), 160'(exp_bursts[i]));
        check({tag, " word_count"}, 160'(wb), 160'(we));
        for (int i = 0; i < wb && i < we; i++)
            check({tag, " word"}, 160'(obs_words[i]), 160'(exp_words[i]));
    endtask

    // Called and returns at a negedge; leaves cmd_valid low.
    task automatic drive_cmd(input logic [22:0] addr, input int len, output int cycles);
        bit ok = 0;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        cycles = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge c);
            cycles++;
            if (bus.cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("cmd_accept_timeout", 160'(0), 160'(1));
        @(negedge c);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int len, input string tag);
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge c);
            if (obs_words.size() >= len && !bus.busy && bus.cmd_ready) begin
                done = 1;
                break;
            end
        end
        check({tag, " done"}, 160'(done), 160'(1));
    endtask

    task automatic run(input logic [22:0] addr, input int len, input string tag);
        int cyc;
        obs_bursts.delete();
        obs_words.delete();
        build_model(addr, len);
        drive_cmd(addr, len, cyc);
        wait_done(len, tag);
        compare(tag);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc0, cyc1;
        bit ok;
        bus.cmd_addr          = '0;
        bus.cmd_len           = '0;
        bus.cmd_valid         = 1'b0;
        bus.txs_waitrequest   = 1'b0;
        bus.txs_readdata      = '0;
        bus.txs_readdatavalid = 1'b0;
        bus.q_ready           = 1'b1;
        repeat (3) @(negedge c);
        check("rst cmd_ready", 160'(bus.cmd_ready), 160'(1));
        check("rst txs_read", 160'(bus.txs_read), 160'(0));
        check("rst txs_address", 160'(bus.txs_address), 160'(0));
        check("rst burstcount", 160'(bus.txs_burstcount), 160'(0));
        check("rst qv_qe_busy", 160'({bus.qv, bus.qe, bus.busy}), 160'(0));
        rst = 1'b0;
        @(negedge c);

        run(23'h1000, 16, "aligned");
        run(23'h1030, 10, "unaligned");

        stall_cycles = 0;
        stall_left   = 5;
        run(23'h5000, 12, "stall");
        check("stall cycles", 160'(stall_cycles), 160'(5));
        check("stall hold", 160'(hold_viol), 160'(0));

        // Credit: downstream blocked, only FIFO_DEPTH words may be in flight.
        ready_mode = 2;
        obs_bursts.delete();
        obs_words.delete();
        build_model(23'h0, 32);
        drive_cmd(23'h0, 32, cyc0);
        repeat (60) @(negedge c);
        check("credit bursts_blocked", 160'(obs_bursts.size()), 160'(2));
        check("credit head", 160'({bus.qv, bus.qe, bus.q}),
              160'({1'b1, exp_words[0]}));
        ready_mode = 1;
        wait_done(32, "credit");
        compare("credit");
        check("credit max_occ", 160'(max_occ <= int'(DEPTH)), 160'(1));
        ready_mode = 0;

        // Zero-length command followed immediately by a one-word command.
        obs_bursts.delete();
        obs_words.delete();
        build_model(23'h2000, 1);
        drive_cmd(23'h1230, 0, cyc0);
        drive_cmd(23'h2000, 1, cyc1);
        check("b2b accept_cycles", 160'(cyc1), 160'(1));
        wait_done(1, "b2b");
        compare("b2b");

        // Reset while the second burst is stalled with four words outstanding.
        hold_rsp = 1;
        obs_bursts.delete();
        obs_words.delete();
        drive_cmd(23'h4040, 8, cyc0);
        for (int i = 0; i < 200; i++) begin
            if (obs_bursts.size() >= 1) break;
            @(negedge c);
        end
        force_wait = 1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge c);
            if (bus.txs_read) begin
                ok = 1;
                break;
            end
        end
        check("rst_mid in_issue", 160'(ok), 160'(1));
        check("rst_mid pending", 160'(rsp_q.size()), 160'(4));
        #2 rst = 1'b1;
        #1;
        check("rst_mid cmd_ready", 160'(bus.cmd_ready), 160'(1));
        check("rst_mid txs", 160'({bus.txs_read, bus.txs_address, bus.txs_burstcount}),
              160'(0));
        check("rst_mid qv_qe_busy", 160'({bus.qv, bus.qe, bus.busy}), 160'(0));
        @(negedge c);
        rst        = 1'b0;
        force_wait = 0;
        hold_rsp   = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_q.size() == 0) break;
            @(negedge c);
        end
        repeat (5) @(negedge c);
        check("rst_mid stale_dropped", 160'({bus.qv, bus.busy}), 160'(0));
        check("rst_mid no_words", 160'(obs_words.size()), 160'(0));
        run(23'h3000, 8, "after_rst");

        // Randomized waitrequest, return timing and downstream ready.
        rand_wait  = 1;
        ready_mode = 1;
        run(23'h7FFFC0, 8, "wrap");
        for (int n = 0; n < 6; n++)
            run(23'($urandom), int'($urandom_range(1, 40)), "random");
        check("final hold", 160'(hold_viol), 160'(0));
        check("final max_occ", 160'(max_occ <= int'(DEPTH)), 160'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
